fetch_controller: RTL and testbench

Sequences instruction fetch out of the combinational-read InstructionMemory (32-bit byte address, word-aligned, 32-bit instruction out). Owns the program counter and drives the memory address. Buffers fetched words in a 2-entry queue and hands them to decode over a valid/ready handshake. Accepts branch/jump redirects from execute, and halts at the end of the instruction space.

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_queue.sv | 57 +++++
 rtl/fetch_controller.sv | 134 +++++++++++++
 tb/tb_fetch_controller.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller: FSM states, fetch entry
// layout and the redirect-target classification helper.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } fetch_state_e;

   localparam logic [31:0] WORD_BYTES = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Misalignment outranks the out-of-range check: a bad target always faults.
   function automatic fetch_state_e redirect_state(input logic [31:0] target,
                                                   input logic [31:0] last_addr);
      if (target[1:0] != 2'b00) begin
         return FAULT;
      end else if (target > last_addr) begin
         return HALT;
      end else begin
         return RUN;
      end
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} words. Flush overrides push and pop;
// the caller guarantees push only when there is room (or a pop frees it).
module fetch_queue
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t entry_i,
   output logic [1:0]   count_o,
   output fetch_entry_t head_o
);

   fetch_entry_t slot_q [2];
   logic         head_q, head_d;
   logic [1:0]   count_q, count_d;
   logic         wr_ptr;

   // With two slots the tail is head+count mod 2; when full, the write
   // lands in the head slot that the simultaneous pop is vacating.
   assign wr_ptr = head_q ^ count_q[0];

   always_comb begin
      head_d  = head_q;
      count_d = count_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         if (pop_i) begin
            head_d = ~head_q;
         end
         count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= 1'b0;
         count_q <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         count_q <= count_d;
         if (push_i && !flush_i) begin
            slot_q[wr_ptr] <= entry_i;
         end
      end
   end

   assign count_o = count_q;
   assign head_o  = slot_q[head_q];

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, buffers fetched words for decode
// and handles redirects. Optional counters are enabled by FETCH_PERF_EN.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] LAST_ADDR = 32'd1020,
   parameter int          DEPTH     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted,
   output logic        fault
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
`endif
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         redir, pop_req, can_accept, push, pop;
   logic [1:0]   count;
   fetch_entry_t head, entry_in;

   if (DEPTH != 2) begin : g_depth_check
      $error("fetch_controller supports DEPTH == 2 only");
   end

   fetch_queue u_queue (
      .clk     (clk),
      .rst     (reset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redir),
      .entry_i (entry_in),
      .count_o (count),
      .head_o  (head)
   );

   // Redirects are ignored once faulted; otherwise they beat push and pop.
   always_comb begin
      redir          = redirect_valid && (state_q != FAULT);
      pop_req        = out_valid && out_ready;
      can_accept     = (count != 2'd2) || pop_req;
      push           = (state_q == RUN) && !redir && can_accept;
      pop            = pop_req && !redir;
      entry_in.pc    = pc_q;
      entry_in.instr = imem_instr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (redir) begin
         pc_d = redirect_pc;
      end else if (push) begin
         pc_d = pc_q + WORD_BYTES;
      end
      case (state_q)
         IDLE: begin
            if (redir) begin
               state_d = redirect_state(redirect_pc, LAST_ADDR);
            end else if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (redir) begin
               state_d = redirect_state(redirect_pc, LAST_ADDR);
            end else if (push && (pc_q == LAST_ADDR)) begin
               state_d = HALT;
            end
         end
         HALT: begin
            if (redir) begin
               state_d = redirect_state(redirect_pc, LAST_ADDR);
            end
         end
         default: state_d = FAULT;
      endcase
   end

   always_comb begin
      imem_addr = pc_q;
      out_valid = (count != 2'd0);
      out_pc    = head.pc;
      out_instr = head.instr;
      halted    = (state_q == HALT);
      fault     = (state_q == FAULT);
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count_q, stall_count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count_q <= 32'd0;
         stall_count_q <= 32'd0;
      end else begin
         if (pop) begin
            fetch_count_q <= fetch_count_q + 32'd1;
         end
         if ((state_q == RUN) && out_valid && !out_ready) begin
            stall_count_q <= stall_count_q + 32'd1;
         end
      end
   end

   assign fetch_count = fetch_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a
// randomized run, all compared against a queue-based model of fetch behaviour.
module tb_fetch_controller;

   localparam logic [31:0] LAST = 32'd1020;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_HALT  = 2;
   localparam int M_FAULT = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        out_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
   logic        out_valid, halted, fault;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count, stall_count;
`endif

   logic [31:0] mem [0:255];

   always #5 clk = ~clk;
   assign imem_instr = mem[imem_addr[9:2]];

   fetch_controller dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted),
      .fault          (fault)
`ifdef FETCH_PERF_EN
      ,
      .fetch_count    (fetch_count),
      .stall_count    (stall_count)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        mq[$];
   int          m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_fetch, m_stall;
   int          checks = 0;
   int          errors = 0;

   task automatic model_init();
      mq.delete();
      m_mode  = M_IDLE;
      m_pc    = 32'h0;
      m_fetch = 32'h0;
      m_stall = 32'h0;
   endtask

   // Apply the current inputs for one clock and advance the model accordingly.
   task automatic cycle();
      ent_t e;
      bit   redir, popped, can_push;
      int   old_mode;
      old_mode = m_mode;
      redir    = redirect_valid && (m_mode != M_FAULT);
      if (old_mode == M_RUN && mq.size() != 0 && !out_ready) m_stall++;
      if (redir) begin
         mq.delete();
         m_pc = redirect_pc;
         if (redirect_pc[1:0] != 2'b00) m_mode = M_FAULT;
         else if (redirect_pc > LAST)   m_mode = M_HALT;
         else                           m_mode = M_RUN;
      end else begin
         popped   = (mq.size() != 0) && out_ready;
         can_push = (old_mode == M_RUN) && (mq.size() < 2 || popped);
         if (popped) begin
            $display("xfer pc=%08h instr=%08h", mq[0].pc, mq[0].instr);
            void'(mq.pop_front());
            m_fetch++;
         end
         if (can_push) begin
            e.pc    = m_pc;
            e.instr = mem[m_pc[9:2]];
            mq.push_back(e);
            if (m_pc == LAST) m_mode = M_HALT;
            m_pc = m_pc + 32'd4;
         end
         if (old_mode == M_IDLE && start) m_mode = M_RUN;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      out_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_init();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || imem_addr !== 32'h0 ||
          halted !== 1'b0 || fault !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid=%0b pc=%h instr=%h addr=%h halt=%0b fault=%0b, want all zero",
                  out_valid, out_pc, out_instr, imem_addr, halted, fault);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin
         errors++;
         $display("FAIL reset_perf: fetch=%0d stall=%0d, want 0 0", fetch_count, stall_count);
      end
`endif
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (out_valid !== 1'b0 || imem_addr !== 32'h0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: valid=%0b addr=%h halt=%0b, want 0 0 0", out_valid, imem_addr, halted);
         end
      end
   endtask

   task automatic test_stream();
      int          delivered = 0;
      logic [31:0] last_pc = 32'hffff_ffff;
      do_reset();
      out_ready = 1'b1;
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 600 && !(m_mode == M_HALT && mq.size() == 0); i++) begin
         if (out_valid && out_ready) begin
            delivered++;
            last_pc = out_pc;
         end
         cycle();
         checks++;
         if ((out_valid !== (mq.size() != 0)) || (imem_addr !== m_pc) || (halted !== (m_mode == M_HALT)) ||
             (fault !== (m_mode == M_FAULT)) ||
             (mq.size() != 0 && (out_pc !== mq[0].pc || out_instr !== mq[0].instr))) begin
            errors++;
            $display("FAIL stream: valid=%0b pc=%h instr=%h addr=%h halt=%0b, want valid=%0b pc=%h addr=%h mode=%0d",
                     out_valid, out_pc, out_instr, imem_addr, halted, mq.size() != 0,
                     (mq.size() != 0) ? mq[0].pc : 32'h0, m_pc, m_mode);
         end
      end
      checks++;
      if (delivered != 256 || last_pc !== LAST || halted !== 1'b1 || imem_addr !== LAST + 32'd4) begin
         errors++;
         $display("FAIL stream_end: delivered=%0d last=%h halt=%0b addr=%h, want 256 %h 1 %h",
                  delivered, last_pc, halted, imem_addr, LAST, LAST + 32'd4);
      end
   endtask

   task automatic test_stall();
      do_reset();
      out_ready = 1'b1;
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 20 && !(mq.size() != 0 && mq[0].pc == 32'd8); i++) cycle();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd8) begin
         errors++;
         $display("FAIL stall_reach: valid=%0b pc=%h, want 1 00000008", out_valid, out_pc);
      end
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'd8 || out_instr !== mem[2] || imem_addr !== m_pc) begin
            errors++;
            $display("FAIL stall_hold: valid=%0b pc=%h instr=%h addr=%h, want 1 00000008 %h %h",
                     out_valid, out_pc, out_instr, imem_addr, mem[2], m_pc);
         end
      end
      checks++;
      if (imem_addr !== 32'd16) begin
         errors++;
         $display("FAIL stall_pc: addr=%h, want 00000010", imem_addr);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'(8 + 4 * k) || out_instr !== mem[2 + k]) begin
            errors++;
            $display("FAIL stall_release: valid=%0b pc=%h instr=%h, want 1 %h %h",
                     out_valid, out_pc, out_instr, 32'(8 + 4 * k), mem[2 + k]);
         end
         cycle();
      end
   endtask

   task automatic test_redirect();
      do_reset();
      out_ready = 1'b1;
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 20 && !(mq.size() != 0 && mq[0].pc == 32'd12); i++) cycle();
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      cycle();
      redirect_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin
         errors++;
         $display("FAIL redirect_flush: valid=%0b addr=%h, want 0 00000040", out_valid, imem_addr);
      end
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== mem[16]) begin
         errors++;
         $display("FAIL redirect_target: valid=%0b pc=%h instr=%h, want 1 00000040 %h",
                  out_valid, out_pc, out_instr, mem[16]);
      end
   endtask

   task automatic test_fault();
      do_reset();
      out_ready = 1'b1;
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      redirect_valid = 1'b1;
      redirect_pc = 32'h42;
      cycle();
      checks++;
      if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h42) begin
         errors++;
         $display("FAIL fault_enter: fault=%0b valid=%0b addr=%h, want 1 0 00000042", fault, out_valid, imem_addr);
      end
      for (int i = 0; i < 6; i++) begin
         start = i[0];
         redirect_valid = ~i[0];
         redirect_pc = 32'h10;
         cycle();
         checks++;
         if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h42 || halted !== 1'b0) begin
            errors++;
            $display("FAIL fault_sticky: fault=%0b valid=%0b addr=%h halt=%0b, want 1 0 00000042 0",
                     fault, out_valid, imem_addr, halted);
         end
      end
      start = 1'b0;
      redirect_valid = 1'b0;
   endtask

   task automatic test_halt_redirect();
      do_reset();
      out_ready = 1'b1;
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 600 && !(m_mode == M_HALT && mq.size() == 0); i++) cycle();
      checks++;
      if (halted !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_reach: halt=%0b valid=%0b, want 1 0", halted, out_valid);
      end
      redirect_valid = 1'b1;
      redirect_pc = 32'h10;
      cycle();
      redirect_valid = 1'b0;
      checks++;
      if (halted !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 32'h10) begin
         errors++;
         $display("FAIL halt_resume: halt=%0b valid=%0b addr=%h, want 0 0 00000010", halted, out_valid, imem_addr);
      end
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== mem[4]) begin
         errors++;
         $display("FAIL halt_target: valid=%0b pc=%h instr=%h, want 1 00000010 %h", out_valid, out_pc, out_instr, mem[4]);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      out_ready = 1'b0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      cycle();
      checks++;
      if (out_valid !== 1'b1 || imem_addr !== 32'd8 || mq.size() != 2) begin
         errors++;
         $display("FAIL areset_fill: valid=%0b addr=%h, want 1 00000008", out_valid, imem_addr);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || imem_addr !== 32'h0 || halted !== 1'b0 || fault !== 1'b0) begin
         errors++;
         $display("FAIL areset_now: valid=%0b addr=%h halt=%0b fault=%0b, want 0 0 0 0",
                  out_valid, imem_addr, halted, fault);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin
         errors++;
         $display("FAIL areset_perf: fetch=%0d stall=%0d, want 0 0", fetch_count, stall_count);
      end
`endif
      #2;
      reset = 1'b0;
      model_init();
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      int r;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if (m_mode == M_FAULT && $urandom_range(0, 7) == 0) do_reset();
         start = ($urandom_range(0, 15) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         redirect_valid = ($urandom_range(0, 24) == 0) ||
                          (m_mode == M_HALT && mq.size() == 0 && $urandom_range(0, 3) == 0);
         r = int'($urandom_range(0, 19));
         if (r == 0)      redirect_pc = 32'(4 * $urandom_range(0, 255)) | 32'($urandom_range(1, 3));
         else if (r == 1) redirect_pc = 32'd1024 + 32'(4 * $urandom_range(0, 15));
         else if (r < 6)  redirect_pc = LAST - 32'(4 * $urandom_range(0, 3));
         else             redirect_pc = 32'(4 * $urandom_range(0, 255));
         cycle();
         checks++;
         if ((out_valid !== (mq.size() != 0)) || (imem_addr !== m_pc) || (halted !== (m_mode == M_HALT)) ||
             (fault !== (m_mode == M_FAULT)) ||
             (mq.size() != 0 && (out_pc !== mq[0].pc || out_instr !== mq[0].instr))) begin
            errors++;
            $display("FAIL random: valid=%0b pc=%h instr=%h addr=%h halt=%0b fault=%0b, want valid=%0b pc=%h addr=%h mode=%0d",
                     out_valid, out_pc, out_instr, imem_addr, halted, fault, mq.size() != 0,
                     (mq.size() != 0) ? mq[0].pc : 32'h0, m_pc, m_mode);
         end
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (fetch_count !== m_fetch || stall_count !== m_stall) begin
         errors++;
         $display("FAIL random_perf: fetch=%0d stall=%0d, want %0d %0d", fetch_count, stall_count, m_fetch, m_stall);
      end
`endif
      start = 1'b0;
      redirect_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      model_init();
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_fault();
      test_halt_redirect();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
